// File: rtl/dac_ctrl_if.sv
// dac_ctrl_if: sample-side handshake plus 3-wire DAC pins of the serial DAC write controller
interface dac_ctrl_if #(
    parameter int DW = 8
);
    logic          dac_en;
    logic [DW-1:0] din;
    logic          dac_cs_n;
    logic          dac_sclk;
    logic          dac_din;
    logic          busy;
    logic          done;
    modport master (output dac_en, din, input dac_cs_n, dac_sclk, dac_din, busy, done);
    modport slave  (input dac_en, din, output dac_cs_n, dac_sclk, dac_din, busy, done);
endinterface

// File: rtl/dac_ctrl.sv
// dac_ctrl: framed 3-wire serial DAC write (CS_n setup, MSB-first bits on divided SCLK, hold, deselect gap)
module dac_ctrl #(
    parameter int DW      = 8,
    parameter int DIV_END = 124,
    parameter int STA_END = 99,
    parameter int GAP_END = 849
) (
    input logic       s_clk,
    input logic       s_rst_n,
    dac_ctrl_if.slave bus
);
    localparam int MAXC = (DIV_END > STA_END) ? ((DIV_END > GAP_END) ? DIV_END : GAP_END)
                                              : ((STA_END > GAP_END) ? STA_END : GAP_END);
    localparam int CW = $clog2(MAXC + 1);
    localparam int BW = $clog2(DW) + 1;
    localparam logic [CW-1:0] DIV_C  = CW'(DIV_END);
    localparam logic [CW-1:0] STA_C  = CW'(STA_END);
    localparam logic [CW-1:0] GAP_C  = CW'(GAP_END);
    localparam logic [BW-1:0] LAST_B = BW'(DW - 1);
    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        STA   = 5'b00010,
        WRITE = 5'b00100,
        STO   = 5'b01000,
        GAP   = 5'b10000
    } state_t;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [BW-1:0] bit_cnt, bit_n;
    logic [DW-1:0] shift, shift_n;
    logic          cs_n, cs_n_n;
    logic          sclk, sclk_n;
    logic          sdo;
    logic          busy, busy_n;
    logic          done, done_n;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        cs_n_n  = cs_n;
        sclk_n  = sclk;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            IDLE: if (bus.dac_en) begin
                state_n = STA;
                cnt_n   = '0;
                shift_n = bus.din;
                cs_n_n  = 1'b0;
                busy_n  = 1'b1;
            end
            STA: if (cnt == STA_C) begin
                state_n = WRITE;
                cnt_n   = '0;
                bit_n   = '0;
            end else cnt_n = cnt + 1'b1;
            WRITE: if (cnt != DIV_C) cnt_n = cnt + 1'b1;
            else begin
                cnt_n  = '0;
                sclk_n = ~sclk;
                // the DAC latched the current bit on the rise; advance on the fall
                if (sclk) begin
                    shift_n = {shift[DW-2:0], 1'b0};
                    bit_n   = bit_cnt + 1'b1;
                    state_n = (bit_cnt == LAST_B) ? STO : WRITE;
                end
            end
            STO: if (cnt == DIV_C) begin
                state_n = GAP;
                cnt_n   = '0;
                cs_n_n  = 1'b1;
            end else cnt_n = cnt + 1'b1;
            GAP: if (cnt == GAP_C) begin
                state_n = IDLE;
                cnt_n   = '0;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end else cnt_n = cnt + 1'b1;
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                bit_n   = '0;
                shift_n = '0;
                cs_n_n  = 1'b1;
                sclk_n  = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end
    always_ff @(posedge s_clk) begin
        if (!s_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            cs_n    <= 1'b1;
            sclk    <= 1'b0;
            sdo     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            cs_n    <= cs_n_n;
            sclk    <= sclk_n;
            sdo     <= shift_n[DW-1];
            busy    <= busy_n;
            done    <= done_n;
        end
    end
    assign bus.dac_cs_n = cs_n;
    assign bus.dac_sclk = sclk;
    assign bus.dac_din  = sdo;
    assign bus.busy     = busy;
    assign bus.done     = done;
endmodule

// File: tb/tb_dac_ctrl.sv
// tb_dac_ctrl: random and directed frames checked every cycle against a time-offset model of the DAC frame
module tb_dac_ctrl;
    localparam int DW = 8, DIV_END = 124, STA_END = 99, GAP_END = 849;
    localparam int W0 = STA_END + 1;
    localparam int WL = 2 * DW * (DIV_END + 1);
    localparam int CS_LOW = W0 + WL + DIV_END + 1;
    localparam int FRAME = CS_LOW + GAP_END + 1;

    logic s_clk = 1'b0;
    logic s_rst_n = 1'b0;
    dac_ctrl_if #(.DW(DW)) bus ();
    dac_ctrl #(.DW(DW), .DIV_END(DIV_END), .STA_END(STA_END), .GAP_END(GAP_END)) dut (
        .s_clk  (s_clk),
        .s_rst_n(s_rst_n),
        .bus    (bus)
    );
    always #10 s_clk = ~s_clk;

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // frame model: outputs are a pure function of cycles elapsed since acceptance
    bit            m_act = 1'b0;
    int            m_t = 0;
    logic [DW-1:0] m_d = '0;
    logic [DW-1:0] exp_words[$];
    logic [DW-1:0] obs_words[$];
    int            obs_rises[$];
    int            falls[$];

    function automatic logic [4:0] model_out(input bit act, input int t, input logic [DW-1:0] d);
        logic [4:0] o;
        if (!act) return 5'b10000;
        o[4] = (t >= CS_LOW);
        o[3] = (t >= W0 && t < W0 + WL) ? (((t - W0) / (DIV_END + 1)) % 2 == 1) : 1'b0;
        o[2] = (t < W0) ? d[DW-1] : ((t < W0 + WL) ? d[DW-1-(t-W0)/(2*(DIV_END+1))] : 1'b0);
        o[1] = (t < FRAME);
        o[0] = (t == FRAME);
        return o;
    endfunction

    always @(posedge s_clk) begin
        if (!s_rst_n) begin
            m_act <= 1'b0;
            m_t   <= 0;
        end else if ((!m_act || m_t == FRAME) && bus.dac_en) begin
            m_act <= 1'b1;
            m_t   <= 0;
            m_d   <= bus.din;
            exp_words.push_back(bus.din);
        end else if (m_act) begin
            if (m_t == FRAME) m_act <= 1'b0;
            else m_t <= m_t + 1;
        end
    end

    bit chk_on = 1'b0;
    task automatic cmp_all();
        logic [4:0] e;
        e = model_out(m_act, m_t, m_d);
        chk("cs_n", bus.dac_cs_n, e[4]);
        chk("sclk", bus.dac_sclk, e[3]);
        chk("din", bus.dac_din, e[2]);
        chk("busy", bus.busy, e[1]);
        chk("done", bus.done, e[0]);
    endtask
    always @(negedge s_clk) if (chk_on) cmp_all();

    // pin monitor: decodes what the DAC itself would see
    int            cyc = 0, rises = 0, tot_rises = 0, cs_fall = 0, cs_len = 0, dones = 0, done_cyc = 0;
    logic          p_sclk = 1'b0, p_cs = 1'b1;
    logic [DW-1:0] word = '0;
    always @(negedge s_clk) begin
        cyc    <= cyc + 1;
        p_sclk <= bus.dac_sclk;
        p_cs   <= bus.dac_cs_n;
        if (bus.dac_sclk === 1'b1 && p_sclk === 1'b0) begin
            word      <= {word[DW-2:0], bus.dac_din};
            rises     <= rises + 1;
            tot_rises <= tot_rises + 1;
        end
        if (bus.dac_cs_n === 1'b0 && p_cs === 1'b1) begin
            cs_fall <= cyc;
            falls.push_back(cyc);
        end
        if (bus.dac_cs_n === 1'b1 && p_cs === 1'b0) begin
            obs_words.push_back(word);
            obs_rises.push_back(rises);
            cs_len <= cyc - cs_fall;
            word   <= '0;
            rises  <= 0;
        end
        if (bus.done === 1'b1) begin
            dones    <= dones + 1;
            done_cyc <= cyc;
        end
    end

    task automatic clr();
        obs_words.delete();
        exp_words.delete();
        obs_rises.delete();
        falls.delete();
    endtask
    task automatic frame(input logic [DW-1:0] d);
        @(negedge s_clk);
        bus.dac_en = 1'b1;
        bus.din    = d;
        @(negedge s_clk);
        bus.dac_en = 1'b0;
    endtask
    task automatic wait_done(input string name);
        int i = 0;
        while (i < FRAME + 10 && bus.done !== 1'b1) begin
            @(negedge s_clk);
            i++;
        end
        chk(name, bus.done, 1'b1);
    endtask

    initial begin
        #(20 * 95000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] mo;
        int d0;
        bus.dac_en = 1'b1;
        bus.din    = 8'hFF;
        mo = model_out(1'b1, 224, 8'hA5);
        chk("pin_sclk_224", mo[3], 1'b0);
        mo = model_out(1'b1, 225, 8'hA5);
        chk("pin_sclk_225", mo[3], 1'b1);
        mo = model_out(1'b1, 350, 8'hA5);
        chk("pin_din_bit6", mo[2], 1'b0);
        mo = model_out(1'b1, 2225, 8'hA5);
        chk("pin_cs_2225", mo[4], 1'b1);
        mo = model_out(1'b1, 3075, 8'hA5);
        chk("pin_done_3075", {mo[1], mo[0]}, 2'b01);
        @(posedge s_clk);
        chk_on = 1'b1;
        repeat (5) @(negedge s_clk);
        chk("rst_no_sclk", tot_rises, 0);
        chk("rst_cs_n", bus.dac_cs_n, 1'b1);
        s_rst_n    = 1'b1;
        bus.dac_en = 1'b0;
        repeat (3) @(negedge s_clk);

        clr();
        d0 = dones;
        frame(8'hA5);
        wait_done("a5_done");
        repeat (3) @(negedge s_clk);
        chk("a5_frames", obs_words.size(), 1);
        chk("a5_word", obs_words[0], 8'hA5);
        chk("a5_rises", obs_rises[0], 8);
        chk("a5_cs_low", cs_len, 2225);
        chk("a5_done_at", done_cyc - cs_fall, 3075);
        chk("a5_dones", dones - d0, 1);

        clr();
        frame(8'h00);
        wait_done("w00_done");
        frame(8'hFF);
        wait_done("wff_done");
        repeat (3) @(negedge s_clk);
        chk("bnd_frames", obs_words.size(), 2);
        chk("bnd_00", obs_words[0], 8'h00);
        chk("bnd_ff", obs_words[1], 8'hFF);
        chk("bnd_ff_rises", obs_rises[1], 8);

        clr();
        d0 = dones;
        @(negedge s_clk);
        bus.dac_en = 1'b1;
        bus.din    = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            @(negedge s_clk);
            wait_done("b2b_done");
            if (k == 2) bus.dac_en = 1'b0;
        end
        repeat (10) @(negedge s_clk);
        chk("b2b_dones", dones - d0, 3);
        chk("b2b_frames", falls.size(), 3);
        chk("b2b_gap01", falls[1] - falls[0], FRAME + 1);
        chk("b2b_gap12", falls[2] - falls[1], FRAME + 1);
        for (int k = 0; k < 3; k++) chk("b2b_word", obs_words[k], 8'h3C);
        chk("b2b_idle", bus.busy, 1'b0);

        clr();
        d0 = dones;
        frame(8'h5A);
        repeat (499) @(negedge s_clk);
        bus.dac_en = 1'b1;
        bus.din    = 8'h81;
        @(negedge s_clk);
        bus.dac_en = 1'b0;
        wait_done("ign_done");
        repeat (200) @(negedge s_clk);
        chk("ign_dones", dones - d0, 1);
        chk("ign_frames", obs_words.size(), 1);
        chk("ign_word", obs_words[0], 8'h5A);

        frame(8'h96);
        repeat (999) @(negedge s_clk);
        s_rst_n = 1'b0;
        @(negedge s_clk);
        s_rst_n = 1'b1;
        chk("mrst_cs_n", bus.dac_cs_n, 1'b1);
        chk("mrst_sclk", bus.dac_sclk, 1'b0);
        chk("mrst_busy", bus.busy, 1'b0);
        d0 = dones;
        repeat (100) @(negedge s_clk);
        chk("mrst_no_done", dones - d0, 0);
        clr();
        frame(8'hC3);
        wait_done("c3_done");
        repeat (3) @(negedge s_clk);
        chk("c3_frames", obs_words.size(), 1);
        chk("c3_word", obs_words[0], 8'hC3);

        clr();
        repeat (4 * FRAME) begin
            @(negedge s_clk);
            bus.din    = DW'($urandom);
            bus.dac_en = ($urandom_range(0, 63) == 0);
        end
        bus.dac_en = 1'b0;
        repeat (FRAME + 10) @(negedge s_clk);
        chk("rnd_idle", bus.busy, 1'b0);
        chk("rnd_frames", obs_words.size(), exp_words.size());
        for (int k = 0; k < obs_words.size() && k < exp_words.size(); k++)
            chk("rnd_word", obs_words[k], exp_words[k]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dac_ctrl.md
# dac_ctrl

Serial DAC write controller for the converter front end. It accepts a parallel sample with a start strobe and builds one framed serial write on the 50 MHz system clock: chip-select setup, DW data bits MSB first on a divided serial clock, chip-select hold, and a minimum deselect gap. It sits between sample-generation logic and an off-chip 3-wire DAC (CS_n / SCLK / DIN), and is the transmit-side companion to the ADC read controller.

## Interface
- DW, 8: data word width in bits.
- DIV_END, 124: SCLK half period is DIV_END+1 s_clk cycles (default 2.5 us half period, 200 kHz SCLK).
- STA_END, 99: CS_n-low-to-first-SCLK setup is STA_END+1 cycles.
- GAP_END, 849: minimum CS_n-high time after a frame is GAP_END+1 cycles (DAC update/settle).
- s_clk  in  1  system clock, 50 MHz; all logic on its rising edge.
- s_rst_n  in  1  reset, synchronous, active-low.
- dac_en  in  1  start request; sampled only in IDLE.
- din  in  DW  sample to write; captured on the accepting cycle.
- dac_cs_n  out  1  DAC chip select, active low.
- dac_sclk  out  1  DAC serial clock; DAC samples dac_din on its rising edge.
- dac_din  out  1  serial data, MSB first.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at frame completion.

## Operation
- One-hot FSM: IDLE, STA, WRITE, STO, GAP. Default/illegal state -> IDLE.
- IDLE: dac_cs_n=1, dac_sclk=0, dac_din=0, busy=0. dac_en=1 at an edge -> STA; same edge loads shift register with din, sets dac_cs_n=0, busy=1.
- STA: holds STA_END+1 cycles; dac_din = shift[DW-1]; dac_sclk=0. Then -> WRITE.
- WRITE: DW bit periods, each = DIV_END+1 cycles SCLK low then DIV_END+1 cycles SCLK high. At each SCLK falling edge (end of high phase) shift register shifts left with 0 fill; dac_din always = shift[DW-1]. After the DW-th high phase ends (SCLK back to 0) -> STO.
- STO: dac_cs_n=0, dac_sclk=0 for DIV_END+1 cycles (hold), then -> GAP with dac_cs_n=1.
- GAP: dac_cs_n=1, busy=1 for GAP_END+1 cycles, then -> IDLE; done=1 for exactly that first IDLE cycle, busy=0 same cycle.
- dac_en while not in IDLE ignored; din changes after capture ignored.
- dac_en high in the done cycle is accepted (back-to-back frames).
- Bit counter width ceil(log2(DW))+1; divider counter wide enough for max(DIV_END, STA_END, GAP_END).

## Timing
- All outputs registered; reset values: dac_cs_n=1, dac_sclk=0, dac_din=0, busy=0, done=0, state IDLE, counters 0, shift register 0.
- With acceptance edge E0 (defaults): dac_cs_n falls at E0; first SCLK rise at E0+225; rise k (k=0..DW-1) at E0+225+250k; last SCLK fall at E0+2100; dac_cs_n rises at E0+2225; done at E0+3075.
- Generic: CS_n low = (STA_END+1)+2·DW·(DIV_END+1)+(DIV_END+1) cycles; frame period = that + GAP_END+1.
- dac_din stable for the full SCLK high phase and DIV_END+1 cycles before each rise; changes only on SCLK fall or state entry.
- Reset mid-frame: at the next edge with s_rst_n=0 all outputs take reset values, frame abandoned, no done pulse; first frame after release needs a new dac_en.

## Test plan
- Reset: hold s_rst_n=0 5 cycles with dac_en=1 -> dac_cs_n=1, dac_sclk=0, dac_din=0, busy=0, done=0 throughout; no SCLK activity.
- Single frame din=8'hA5 -> exactly 8 SCLK rises, sampled bits 1,0,1,0,0,1,0,1; dac_cs_n low 2225 cycles; done one cycle at E0+3075; busy high E0..E0+3074.
- Boundary words din=8'h00 then 8'hFF -> sampled 00 and FF; dac_din constant across all rises of each frame.
- dac_en held high continuously with din=8'h3C -> frames start every 3076 cycles, each sampling 8'h3C, one done per frame.
- dac_en pulsed with din=8'h81 at E0+500 during frame of 8'h5A -> frame outputs 8'h5A only, no second frame, single done.
- s_rst_n=0 for one cycle at E0+1000 (mid-WRITE) -> next edge dac_cs_n=1, dac_sclk=0, busy=0, no done; subsequent dac_en with 8'hC3 produces clean frame sampling 8'hC3.
